// File: rtl/alu_op_queue.sv
// Two-entry request queue in front of an external combinational ALU, with a registered result stage.
// Optional illegal-opcode filtering (opcodes 13..15) is enabled by defining ALU_OPQ_OPCHK_EN.
module alu_op_queue (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [3:0]  in_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [3:0]  out_op,
  output logic [1:0]  count,
  output logic        err_illegal
);

  logic [31:0] mem_a [2];
  logic [31:0] mem_b [2];
  logic [3:0]  mem_op [2];

  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_result_q, out_result_d;
  logic [3:0]  out_op_q, out_op_d;

  logic accept;
  logic illegal;
  logic enq;
  logic pop;
  logic head_valid;

`ifdef ALU_OPQ_OPCHK_EN
  logic err_q;

  assign illegal = (in_op >= 4'd13);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= accept & illegal;
    end
  end

  assign err_illegal = err_q;
`else
  assign illegal     = 1'b0;
  assign err_illegal = 1'b0;
`endif

  // in_ready depends only on occupancy: a full queue never takes a request,
  // even when the head is being popped in the same cycle.
  assign in_ready   = (count_q != 2'd2);
  assign accept     = in_valid & in_ready;
  assign enq        = accept & ~illegal;
  assign head_valid = (count_q != 2'd0);
  assign pop        = head_valid & (~out_valid_q | out_ready);

  assign alu_a  = head_valid ? mem_a[rd_ptr_q]  : 32'd0;
  assign alu_b  = head_valid ? mem_b[rd_ptr_q]  : 32'd0;
  assign alu_op = head_valid ? mem_op[rd_ptr_q] : 4'd0;

  always_ff @(posedge clk) begin
    if (enq) begin
      mem_a[wr_ptr_q]  <= in_a;
      mem_b[wr_ptr_q]  <= in_b;
      mem_op[wr_ptr_q] <= in_op;
    end
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_op_d     = out_op_q;

    if (enq) begin
      wr_ptr_d = ~wr_ptr_q;
    end

    // A pop refills the output register even while it is being drained.
    if (pop) begin
      rd_ptr_d     = ~rd_ptr_q;
      out_valid_d  = 1'b1;
      out_result_d = alu_result;
      out_op_d     = alu_op;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case ({enq, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      out_valid_q  <= 1'b0;
      out_result_q <= 32'd0;
      out_op_q     <= 4'd0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_op_q     <= out_op_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_op     = out_op_q;
  assign count      = count_q;

endmodule

// File: tb/tb_alu_op_queue.sv
// Scoreboard bench for alu_op_queue: directed requests, a stand-in combinational ALU,
// and a monitor that checks every output transfer in order. Honours ALU_OPQ_OPCHK_EN.
module tb_alu_op_queue;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = 32'd0;
  logic [31:0] in_b = 32'd0;
  logic [3:0]  in_op = 4'd0;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [3:0]  out_op;
  logic [1:0]  count;
  logic        err_illegal;

  int checks = 0;
  int failures = 0;
  bit done = 1'b0;
  logic [35:0] sb_q [$];

  alu_op_queue dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_op(out_op),
    .count(count), .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  // Stand-in ALU. Shifts take their value from b and the distance from b[4:0];
  // undefined opcodes return a recognisable marker.
  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
    case (op)
      4'd0:    return ~a;
      4'd1:    return ~b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ~(a ^ b);
      4'd6:    return {31'd0, a < b};
      4'd7:    return {31'd0, a > b};
      4'd8:    return b << b[4:0];
      4'd9:    return b >> b[4:0];
      4'd10:   return 32'($signed(b) >>> b[4:0]);
      4'd11:   return a + b;
      4'd12:   return a - b;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always_comb alu_result = alu_model(alu_a, alu_b, alu_op);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic sb_push(input logic [31:0] res, input logic [3:0] op);
    sb_q.push_back({op, res});
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that accepted the request.
  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    logic rdy;
    int n;
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 50);
    if (!rdy) chk("push_timeout", 32'(rdy), 32'd1);
    $display("push a=%h b=%h op=%0d", a, b, op);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_timeout", 32'(n < 100), 32'd1);
    chk("drain_count", 32'(count), 32'd0);
  endtask

  task automatic monitor();
    logic [35:0] exp;
    while (!done) begin
      @(negedge clk);
      if (reset_n && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out actual=%h/%0d required=none", out_result, out_op);
        end else begin
          exp = sb_q.pop_front();
          $display("result %h op=%0d", out_result, out_op);
          chk("out_result", out_result, exp[31:0]);
          chk("out_op", 32'(out_op), 32'(exp[35:32]));
        end
      end
    end
  endtask

  task automatic stimulus();
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_err", 32'(err_illegal), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Single ADD: two-cycle latency
    out_ready = 1'b1;
    sb_push(32'd8, 4'd11);
    push(32'd5, 32'd3, 4'd11);
    chk("lat_count1", 32'(count), 32'd1);
    chk("lat_valid_early", 32'(out_valid), 32'd0);
    chk("head_alu_a", alu_a, 32'd5);
    @(posedge clk);
    #1;
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_result", out_result, 32'd8);
    chk("lat_count0", 32'(count), 32'd0);
    @(posedge clk);
    #1;
    chk("lat_valid_clear", 32'(out_valid), 32'd0);

    // Ordered SUB / ASR plus a back-to-back stream of other ops
    sb_push(32'hFFFF_FFFE, 4'd12);
    sb_push(32'hC000_0000, 4'd10);
    sb_push(32'hFFFF_FFFF, 4'd0);
    sb_push(32'hF00F_F00F, 4'd5);
    sb_push(32'd1, 4'd6);
    sb_push(32'h0000_0040, 4'd8);
    push(32'd3, 32'd5, 4'd12);
    push(32'd0, 32'h8000_0001, 4'd10);
    push(32'd0, 32'h1234_5678, 4'd0);
    push(32'h0F0F_0F0F, 32'h00FF_00FF, 4'd5);
    push(32'd3, 32'd7, 4'd6);
    push(32'd1, 32'd4, 4'd8);
    wait_drain();

    // Backpressure: output reg plus two entries fill up
    out_ready = 1'b0;
    sb_push(32'h0000_F000, 4'd2);
    sb_push(32'h0000_00FF, 4'd3);
    sb_push(32'h0000_00F0, 4'd4);
    push(32'h0000_F0F0, 32'h0000_FF00, 4'd2);
    push(32'h0000_000F, 32'h0000_00F0, 4'd3);
    push(32'h0000_00FF, 32'h0000_000F, 4'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_count", 32'(count), 32'd2);
    chk("full_valid", 32'(out_valid), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_result", out_result, 32'h0000_F000);
    chk("hold_op", 32'(out_op), 32'd2);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("stream_r1", out_result, 32'h0000_00FF);
    chk("stream_v1", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    chk("stream_r2", out_result, 32'h0000_00F0);
    chk("stream_v2", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    chk("stream_v3", 32'(out_valid), 32'd0);
    wait_drain();

    // Undefined opcode
`ifdef ALU_OPQ_OPCHK_EN
    push(32'd1, 32'd2, 4'd14);
    chk("ill_err", 32'(err_illegal), 32'd1);
    chk("ill_count", 32'(count), 32'd0);
    chk("ill_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("ill_err_clear", 32'(err_illegal), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("ill_no_valid", 32'(out_valid), 32'd0);
`else
    sb_push(32'hDEAD_BEEF, 4'd14);
    push(32'd1, 32'd2, 4'd14);
    chk("undef_err", 32'(err_illegal), 32'd0);
    wait_drain();
`endif

    // Asynchronous reset while full
    out_ready = 1'b0;
    push(32'd1, 32'd1, 4'd11);
    push(32'd1, 32'd1, 4'd11);
    push(32'd1, 32'd1, 4'd11);
    chk("pre_rst_count", 32'(count), 32'd2);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_result", out_result, 32'd0);
    chk("arst_op", 32'(out_op), 32'd0);
    chk("arst_alu_b", alu_b, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_no_valid", 32'(out_valid), 32'd0);
    sb_push(32'h0000_0010, 4'd11);
    push(32'h0000_000C, 32'd4, 4'd11);
    wait_drain();

    done = 1'b1;
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join
    chk("sb_leftover", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_op_queue.md
ALU_OP_QUEUE -- requirements
Module: alu_op_queue

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port reset_n, input, 1, reset, asynchronous and active-low.
REQ-003 SHALL have port in_valid, input, 1, upstream request valid.
REQ-004 SHALL have port in_ready, output, 1, queue can accept a request.
REQ-005 SHALL have ports in_a and in_b, input, 32 each, operands.
REQ-006 SHALL have port in_op, input, 4, ALU opcode: 0 NOT a, 1 NOT b, 2 AND, 3 OR, 4 XOR, 5 XNOR, 6 LESS, 7 GREATER, 8 LSL, 9 LSR, 10 ASR, 11 ADD, 12 SUB; 13-15 undefined.
REQ-007 SHALL have ports alu_a, alu_b (output, 32) and alu_op (output, 4), driving the combinational 32-bit ALU from the queue head.
REQ-008 SHALL have port alu_result, input, 32, combinational ALU result for alu_a/alu_b/alu_op.
REQ-009 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_result (output, 32), out_op (output, 4): registered result with opcode.
REQ-010 SHALL have port count, output, 2, queue occupancy 0..2.
REQ-011 SHALL have port err_illegal, output, 1, one-cycle illegal-opcode pulse; tied 0 without ALU_OPQ_OPCHK_EN.

Function
REQ-012 SHALL hold a 2-entry FIFO of {a, b, op}; in_ready = (count != 2); no same-cycle fill-and-drain bypass when full.
REQ-013 SHALL accept a request on a rising edge with in_valid & in_ready; write pointer 1 bit, wraps 1->0.
REQ-014 SHALL drive alu_a/alu_b/alu_op from the head entry when count != 0; otherwise drive all zeros.
REQ-015 SHALL define pop = (count != 0) & (!out_valid | out_ready); on pop, capture alu_result into out_result and head op into out_op, set out_valid, and advance read pointer (wraps 1->0).
REQ-016 SHALL clear out_valid on out_valid & out_ready without a same-cycle pop; pop and drain together keep out_valid high with new data.
REQ-017 SHALL hold out_result/out_op stable while out_valid & !out_ready.
REQ-018 SHALL provide latency: request accepted on edge E into an empty queue with idle output appears with out_valid high after edge E+1 (2 cycles).
REQ-019 SHALL update count: +1 on accept only, -1 on pop only, unchanged on both; simultaneous accept and pop at count 2 cannot occur (REQ-012).
REQ-020 SHALL sustain one result per cycle with out_ready held high and in_valid held high.

Reset
REQ-021 SHALL, on reset_n low, asynchronously clear count, pointers, out_valid, err_illegal, out_result, out_op to 0; in_ready reads 1 after reset.
REQ-022 SHALL discard all queued and in-flight requests when reset asserts mid-operation; no out_valid until a new request is accepted after reset_n rises.

Configuration
REQ-023 SHALL use macro ALU_OPQ_OPCHK_EN: when defined, an accepted request with in_op 13..15 SHALL be consumed (handshake completes), not enqueued, count unchanged, and err_illegal SHALL pulse high for exactly the following cycle.
REQ-024 SHALL, without ALU_OPQ_OPCHK_EN, enqueue opcodes 13..15 like any other and pass alu_result through unchanged; err_illegal constant 0.

Verification
REQ-025 SHALL cover: reset, push a=5,b=3,op=11, out_ready=1 -> out_valid 2 cycles later, out_result=8, out_op=11, count back to 0.
REQ-026 SHALL cover: push a=3,b=5,op=12 then a=0,b=0x80000001,op=10 -> results 0xFFFFFFFE then 0xC0000000 in order.
REQ-027 SHALL cover: out_ready=0, push 3 requests back to back -> in_ready low after the third accept (output reg + 2 entries), count=2; then out_ready=1 -> three results in order, one per cycle.
REQ-028 SHALL cover: with ALU_OPQ_OPCHK_EN, push op=14 -> in_ready stays 1, count stays 0, err_illegal high one cycle, no out_valid; without macro, out_valid with out_op=14.
REQ-029 SHALL cover: reset_n pulsed low with count=2 and out_valid=1 -> all outputs 0, in_ready 1 immediately; next request completes normally.
